alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Upstream issue stage for alu. Accepts one register-to-register instruction per valid/ready handshake.
//  Reads two operands from a small local register file and drives alu (enable, op_code, op0, op1).
//  Waits for the ALU latency, then writes alu.out back to the destination register.
//  Presents each result on an observation port. Optional load port preloads registers.
// PARAMETERS
//  DATA_WIDTH      4  operand/result width; must equal alu DATA_WIDTH
//  OPCODE_WIDTH    2  op code width; must equal alu OPCODE_WIDTH
//  REG_ADDR_WIDTH  2  register-file address width (2**REG_ADDR_WIDTH registers)
//  ALU_LATENCY     1  clk edges from alu_enable sample to valid alu_out; legal 0..7
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   asynchronous, active-low reset
//  in_valid    in   1   instruction valid
//  in_ready    out  1   instruction accepted when in_valid&&in_ready at rising edge
//  in_op       in   OPCODE_WIDTH    ALU op code
//  in_dst      in   REG_ADDR_WIDTH  destination register
//  in_src0     in   REG_ADDR_WIDTH  operand-0 register
//  in_src1     in   REG_ADDR_WIDTH  operand-1 register
//  ld_en       in   1   register preload strobe
//  ld_addr     in   REG_ADDR_WIDTH  preload address
//  ld_data     in   DATA_WIDTH      preload data
//  alu_enable  out  1   to alu.enable
//  alu_op      out  OPCODE_WIDTH    to alu.op_code
//  alu_op0     out  DATA_WIDTH      to alu.op0
//  alu_op1     out  DATA_WIDTH      to alu.op1
//  alu_out     in   DATA_WIDTH      from alu.out
//  res_valid   out  1   one-cycle pulse: result written back
//  res_dst     out  REG_ADDR_WIDTH  register written
//  res_data    out  DATA_WIDTH      value written
// BEHAVIOUR
//  Reset (reset==0, async):
//   - state=IDLE; all registers=0; all outputs=0 except in_ready.
//   - in_ready=1 once reset deasserts.
//  Reset mid-operation: the in-flight instruction is dropped; no writeback, no res_valid.
//  FSM states: IDLE, ISSUE, WAIT, WB.
//   - IDLE: in_ready=1. On handshake, latch op/dst/src0/src1 and go to ISSUE.
//   - ISSUE, 1 cycle: alu_enable=1; alu_op0=rf[src0], alu_op1=rf[src1], read combinationally from rf.
//     If ALU_LATENCY==0: capture alu_out and go to WB. Otherwise load cnt=ALU_LATENCY and go to WAIT.
//   - WAIT: alu_enable=0; operands held stable. Decrement cnt each cycle.
//     At the edge where cnt==1: capture alu_out into res_data and go to WB.
//   - WB, 1 cycle: rf[dst]<=res_data; res_valid=1, res_dst=dst; go to IDLE.
//  in_ready=0 in ISSUE, WAIT and WB.
//   - Accept-to-res_valid = ALU_LATENCY+2 cycles. Issue period = ALU_LATENCY+3 cycles.
//  Preload: ld_en is honoured only in IDLE and ignored in other states.
//   - If a load coincides with an instruction handshake, the load writes first (same edge).
//     ISSUE then reads the loaded value.
//  dst may equal src0/src1. Register writes occur only in WB, so operands always see the pre-instruction value.
//  res_data/res_dst hold their last values after res_valid drops.
//  Arithmetic is entirely inside alu; this block performs no width change. Data is passed bit-exact.
// STRUCTURE
//  - Shared package/header alu_pkg: DATA_WIDTH, OPCODE_WIDTH, REG_ADDR_WIDTH defaults; FSM state encoding.
//  - Sub-module alu_issue_regfile: 2 async read ports, 1 write port (muxed WB/preload), async clear.
//  - Top level holds the FSM, latency counter and instruction latch.
// TESTING (bench model of alu: op 0=add, 1=sub, 2=and, 3=or, mod 16, registered, latency 1)
//  - Reset: reset=0 mid-WAIT, then release -> res_valid never pulses; all regs read 0; in_ready=1.
//  - Preload r1=3, r2=5; issue add r0=r1+r2 -> alu_enable 1 cycle after accept;
//    res_valid 3 cycles after accept with res_dst=0, res_data=8.
//  - Wrap: r1=12, r2=7, add r3 -> res_data=3. Sub r3=r2-r1 -> res_data=11.
//  - Back-to-back: in_valid held high for 2 instructions -> second accepted exactly 4 cycles after first;
//    in_ready=0 between.
//  - Hazard: r1=6; and r1=r1&r1, then or r2=r1|r0 (r0=8) -> second reads written r1=6; res_data=14.
//  - Load+issue same edge: ld r1=9 with add r0=r1+r1 -> res_data=2. A ld_en during WAIT is ignored.
//  - Repeat the suite with ALU_LATENCY=0 and ALU_LATENCY=3.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared widths and FSM encoding for the alu issue controller
package alu_pkg;
  localparam int DATA_WIDTH     = 4;
  localparam int OPCODE_WIDTH   = 2;
  localparam int REG_ADDR_WIDTH = 2;
  localparam int CNT_WIDTH      = 3;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } state_e;
endpackage

// File: rtl/alu_issue_regfile.sv
// alu_issue_regfile: register file with two async read ports and one sync write port.
// Ports: clk, reset (async active-low clear), we_i/waddr_i/wdata_i write port,
//        raddr0_i/rdata0_o and raddr1_i/rdata1_o combinational read ports.
module alu_issue_regfile #(
  parameter int DW = alu_pkg::DATA_WIDTH,
  parameter int AW = alu_pkg::REG_ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr0_i,
  input  logic [AW-1:0] raddr1_i,
  output logic [DW-1:0] rdata0_o,
  output logic [DW-1:0] rdata1_o
);
  logic [DW-1:0] rf_q [2**AW];
  always_ff @(posedge clk or negedge reset)
    if (!reset) rf_q <= '{default: '0};
    else if (we_i) rf_q[waddr_i] <= wdata_i;
  assign rdata0_o = rf_q[raddr0_i];
  assign rdata1_o = rf_q[raddr1_i];
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one register-to-register instruction at a time to an external alu.
// Ports: clk, reset (async active-low); in_* instruction handshake; ld_* register preload
//        (honoured only while idle); alu_* drive/return of the external alu;
//        res_* one-cycle writeback report, with res_dst/res_data holding afterwards.
module alu_issue_ctrl #(
  parameter int DATA_WIDTH     = alu_pkg::DATA_WIDTH,
  parameter int OPCODE_WIDTH   = alu_pkg::OPCODE_WIDTH,
  parameter int REG_ADDR_WIDTH = alu_pkg::REG_ADDR_WIDTH,
  parameter int ALU_LATENCY    = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OPCODE_WIDTH-1:0]   in_op,
  input  logic [REG_ADDR_WIDTH-1:0] in_dst,
  input  logic [REG_ADDR_WIDTH-1:0] in_src0,
  input  logic [REG_ADDR_WIDTH-1:0] in_src1,
  input  logic                      ld_en,
  input  logic [REG_ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0]     ld_data,
  output logic                      alu_enable,
  output logic [OPCODE_WIDTH-1:0]   alu_op,
  output logic [DATA_WIDTH-1:0]     alu_op0,
  output logic [DATA_WIDTH-1:0]     alu_op1,
  input  logic [DATA_WIDTH-1:0]     alu_out,
  output logic                      res_valid,
  output logic [REG_ADDR_WIDTH-1:0] res_dst,
  output logic [DATA_WIDTH-1:0]     res_data
);
  import alu_pkg::*;
  localparam logic [CNT_WIDTH-1:0] LAT = CNT_WIDTH'(ALU_LATENCY);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  state_e                    state_q, state_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic [OPCODE_WIDTH-1:0]   op_q;
  logic [REG_ADDR_WIDTH-1:0] dst_q, src0_q, src1_q, res_dst_q;
  logic [DATA_WIDTH-1:0]     res_q, rd0, rd1;
  logic                      hs, busy, capture;
  assign hs        = in_valid && in_ready;
  assign busy      = state_q == S_ISSUE || state_q == S_WAIT;
  // alu_out is valid on the edge leaving ISSUE for a zero-latency alu, else on the last WAIT edge
  assign capture   = (state_q == S_ISSUE && ALU_LATENCY == 0) || (state_q == S_WAIT && cnt_q == ONE);
  assign in_ready  = state_q == S_IDLE;
  assign alu_enable = state_q == S_ISSUE;
  assign alu_op    = busy ? op_q : '0;
  assign alu_op0   = busy ? rd0 : '0;
  assign alu_op1   = busy ? rd1 : '0;
  assign res_valid = state_q == S_WB;
  assign res_dst   = res_dst_q;
  assign res_data  = res_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:  state_d = hs ? S_ISSUE : S_IDLE;
      S_ISSUE: begin
        state_d = ALU_LATENCY == 0 ? S_WB : S_WAIT;
        cnt_d   = LAT;
      end
      S_WAIT: begin
        state_d = cnt_q == ONE ? S_WB : S_WAIT;
        cnt_d   = cnt_q - ONE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      dst_q     <= '0;
      src0_q    <= '0;
      src1_q    <= '0;
      res_q     <= '0;
      res_dst_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (hs) begin
        op_q   <= in_op;
        dst_q  <= in_dst;
        src0_q <= in_src0;
        src1_q <= in_src1;
      end
      if (capture) begin
        res_q     <= alu_out;
        res_dst_q <= dst_q;
      end
    end
  // writeback owns the write port in WB; preloads only land while idle
  alu_issue_regfile #(.DW(DATA_WIDTH), .AW(REG_ADDR_WIDTH)) u_rf (
    .clk      (clk),
    .reset    (reset),
    .we_i     (res_valid || (in_ready && ld_en)),
    .waddr_i  (res_valid ? dst_q : ld_addr),
    .wdata_i  (res_valid ? res_q : ld_data),
    .raddr0_i (src0_q),
    .raddr1_i (src1_q),
    .rdata0_o (rd0),
    .rdata1_o (rd1)
  );
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: randomized and directed checks of alu_issue_ctrl at alu latencies 0, 1 and 3
module tb_alu_issue_ctrl;
  logic clk = 0;
  logic reset = 0;
  always #5 clk = ~clk;
  logic       in_valid [3], in_ready [3], ld_en [3], alu_enable [3], res_valid [3];
  logic [1:0] in_op [3], in_dst [3], in_src0 [3], in_src1 [3], ld_addr [3], alu_op [3], res_dst [3];
  logic [3:0] ld_data [3], alu_op0 [3], alu_op1 [3], res_data [3];
  logic [3:0] m [3][4];
  int checks = 0, errors = 0;
  function automatic int lat_of(int k);
    return k == 0 ? 0 : k == 1 ? 1 : 3;
  endfunction
  function automatic logic [3:0] alu_f(logic [1:0] op, logic [3:0] a, logic [3:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction
  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int L = g == 0 ? 0 : g == 1 ? 1 : 3;
    logic [3:0] aout;
    alu_issue_ctrl #(.ALU_LATENCY(L)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_op(in_op[g]), .in_dst(in_dst[g]),
      .in_src0(in_src0[g]), .in_src1(in_src1[g]),
      .ld_en(ld_en[g]), .ld_addr(ld_addr[g]), .ld_data(ld_data[g]),
      .alu_enable(alu_enable[g]), .alu_op(alu_op[g]), .alu_op0(alu_op0[g]), .alu_op1(alu_op1[g]),
      .alu_out(aout),
      .res_valid(res_valid[g]), .res_dst(res_dst[g]), .res_data(res_data[g])
    );
    if (L == 0) begin : comb_alu
      assign aout = alu_f(alu_op[g], alu_op0[g], alu_op1[g]);
    end else begin : pipe_alu
      logic [3:0] pipe [L];
      always @(posedge clk) begin
        pipe[0] <= alu_f(alu_op[g], alu_op0[g], alu_op1[g]);
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      end
      assign aout = pipe[L-1];
    end
  end
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr_in(int k);
    in_valid[k] = 0; in_op[k] = 0; in_dst[k] = 0; in_src0[k] = 0; in_src1[k] = 0;
    ld_en[k] = 0; ld_addr[k] = 0; ld_data[k] = 0;
  endtask
  task automatic do_reset(int k);
    clr_in(k);
    reset = 0;
    tick();
    tick();
    reset = 1;
    tick();
    for (int r = 0; r < 4; r++) m[k][r] = 0;
  endtask
  task automatic load(int k, logic [1:0] a, logic [3:0] d);
    ld_en[k] = 1; ld_addr[k] = a; ld_data[k] = d;
    tick();
    ld_en[k] = 0;
    m[k][a] = d;
  endtask
  task automatic issue(int k, logic [1:0] op, logic [1:0] dst, logic [1:0] s0, logic [1:0] s1,
                       bit ld, logic [1:0] la, logic [3:0] ldd, bit wait_ld);
    int L, n;
    logic [3:0] a, b, e;
    bit seen, quiet;
    string t;
    L = lat_of(k);
    t = $sformatf("L%0d", L);
    n = 0;
    while (!in_ready[k] && n < 20) begin tick(); n++; end
    check({t, " ready_before"}, in_ready[k], 1);
    in_valid[k] = 1; in_op[k] = op; in_dst[k] = dst; in_src0[k] = s0; in_src1[k] = s1;
    ld_en[k] = ld; ld_addr[k] = la; ld_data[k] = ldd;
    if (ld) m[k][la] = ldd;
    a = m[k][s0];
    b = m[k][s1];
    e = alu_f(op, a, b);
    tick();
    in_valid[k] = 0;
    ld_en[k] = 0;
    check({t, " alu_enable"}, alu_enable[k], 1);
    check({t, " alu_op"}, alu_op[k], op);
    check({t, " alu_op0"}, alu_op0[k], a);
    check({t, " alu_op1"}, alu_op1[k], b);
    check({t, " ready_issue"}, in_ready[k], 0);
    seen = 0;
    quiet = 1;
    n = 0;
    while (!seen && n < 20) begin
      tick();
      n++;
      ld_en[k] = 0;
      if (res_valid[k]) seen = 1;
      else begin
        if (in_ready[k] || alu_enable[k] || alu_op0[k] != a || alu_op1[k] != b) quiet = 0;
        // a preload attempted while waiting on the alu must not land
        if (wait_ld && n == 1) begin
          ld_en[k] = 1; ld_addr[k] = s0; ld_data[k] = ~a;
        end
      end
    end
    check({t, " wait_stable"}, quiet, 1);
    check({t, " accept_to_res"}, n + 1, L + 2);
    check({t, " res_dst"}, res_dst[k], dst);
    check({t, " res_data"}, res_data[k], e);
    m[k][dst] = e;
    tick();
    check({t, " res_pulse"}, res_valid[k], 0);
    check({t, " res_hold"}, {res_dst[k], res_data[k]}, {dst, e});
    check({t, " ready_after"}, in_ready[k], 1);
  endtask
  task automatic b2b(int k, logic [1:0] op1, logic [1:0] d1, logic [1:0] a1, logic [1:0] b1,
                     logic [1:0] op2, logic [1:0] d2, logic [1:0] a2, logic [1:0] b2);
    int L, j, n;
    logic [3:0] e1, e2;
    string t;
    L = lat_of(k);
    t = $sformatf("L%0d", L);
    in_valid[k] = 1; in_op[k] = op1; in_dst[k] = d1; in_src0[k] = a1; in_src1[k] = b1;
    e1 = alu_f(op1, m[k][a1], m[k][b1]);
    tick();
    in_op[k] = op2; in_dst[k] = d2; in_src0[k] = a2; in_src1[k] = b2;
    j = 0;
    while (!in_ready[k] && j < 20) begin
      tick();
      j++;
      if (res_valid[k]) begin
        check({t, " b2b_res1"}, res_data[k], e1);
        m[k][d1] = e1;
      end
    end
    check({t, " b2b_period"}, j + 1, L + 3);
    e2 = alu_f(op2, m[k][a2], m[k][b2]);
    tick();
    in_valid[k] = 0;
    n = 0;
    while (!res_valid[k] && n < 20) begin tick(); n++; end
    check({t, " b2b_res2"}, {res_dst[k], res_data[k]}, {d2, e2});
    m[k][d2] = e2;
    tick();
  endtask
  task automatic reset_test(int k);
    int L;
    bit quiet;
    string t;
    L = lat_of(k);
    t = $sformatf("L%0d", L);
    load(k, 2'd1, 4'd5);
    load(k, 2'd2, 4'd7);
    in_valid[k] = 1; in_op[k] = 2'd0; in_dst[k] = 2'd3; in_src0[k] = 2'd1; in_src1[k] = 2'd2;
    tick();
    in_valid[k] = 0;
    if (L > 0) tick();
    reset = 0;
    #1;
    check({t, " rst_outs"}, {alu_enable[k], res_valid[k], alu_op0[k], alu_op1[k], res_data[k], res_dst[k]}, 0);
    check({t, " rst_ready"}, in_ready[k], 1);
    quiet = 1;
    tick();
    tick();
    reset = 1;
    for (int i = 0; i < 8; i++) begin
      if (res_valid[k]) quiet = 0;
      tick();
    end
    check({t, " rst_no_wb"}, quiet, 1);
    check({t, " rst_ready_after"}, in_ready[k], 1);
    for (int r = 0; r < 4; r++) m[k][r] = 0;
    issue(k, 2'd3, 2'd0, 2'd1, 2'd2, 0, 0, 0, 0);
    issue(k, 2'd3, 2'd1, 2'd3, 2'd0, 0, 0, 0, 0);
  endtask
  task automatic suite(int k);
    do_reset(k);
    check($sformatf("L%0d reset_ready", lat_of(k)), in_ready[k], 1);
    check($sformatf("L%0d reset_res", lat_of(k)), {res_valid[k], res_dst[k], res_data[k], alu_enable[k]}, 0);
    load(k, 2'd1, 4'd3);
    load(k, 2'd2, 4'd5);
    issue(k, 2'd0, 2'd0, 2'd1, 2'd2, 0, 0, 0, 0);
    check($sformatf("L%0d add_8", lat_of(k)), res_data[k], 8);
    load(k, 2'd1, 4'd12);
    load(k, 2'd2, 4'd7);
    issue(k, 2'd0, 2'd3, 2'd1, 2'd2, 0, 0, 0, 0);
    check($sformatf("L%0d wrap_3", lat_of(k)), res_data[k], 3);
    issue(k, 2'd1, 2'd3, 2'd2, 2'd1, 0, 0, 0, 0);
    check($sformatf("L%0d sub_11", lat_of(k)), res_data[k], 11);
    b2b(k, 2'd0, 2'd0, 2'd1, 2'd2, 2'd1, 2'd1, 2'd0, 2'd2);
    load(k, 2'd1, 4'd6);
    load(k, 2'd0, 4'd8);
    issue(k, 2'd2, 2'd1, 2'd1, 2'd1, 0, 0, 0, 0);
    issue(k, 2'd3, 2'd2, 2'd1, 2'd0, 0, 0, 0, 0);
    check($sformatf("L%0d hazard_14", lat_of(k)), res_data[k], 14);
    issue(k, 2'd0, 2'd0, 2'd1, 2'd1, 1, 2'd1, 4'd9, 1);
    check($sformatf("L%0d ld_issue_2", lat_of(k)), res_data[k], 2);
    issue(k, 2'd3, 2'd2, 2'd1, 2'd1, 0, 0, 0, 0);
    reset_test(k);
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 2) == 0) load(k, 2'($urandom), 4'($urandom));
      issue(k, 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
            $urandom_range(0, 2) == 0, 2'($urandom), 4'($urandom), $urandom_range(0, 2) == 0);
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    for (int k = 0; k < 3; k++) clr_in(k);
    for (int k = 0; k < 3; k++) suite(k);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
